// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================
// Package  : alu_pkg
// Purpose  : shared encodings and state type for alu_seq
// Revision : 1.0
// ============================================================
package alu_pkg;

  localparam int c_width_default = 32;

  // base funct3 (i_muldiv = 0)
  localparam logic [2:0] c_op_add  = 3'b000;
  localparam logic [2:0] c_op_sll  = 3'b001;
  localparam logic [2:0] c_op_slt  = 3'b010;
  localparam logic [2:0] c_op_sltu = 3'b011;
  localparam logic [2:0] c_op_xor  = 3'b100;
  localparam logic [2:0] c_op_sr   = 3'b101;
  localparam logic [2:0] c_op_or   = 3'b110;
  localparam logic [2:0] c_op_and  = 3'b111;

  // M-extension funct3 (i_muldiv = 1)
  localparam logic [2:0] c_mop_mul    = 3'b000;
  localparam logic [2:0] c_mop_mulh   = 3'b001;
  localparam logic [2:0] c_mop_mulhsu = 3'b010;
  localparam logic [2:0] c_mop_mulhu  = 3'b011;
  localparam logic [2:0] c_mop_div    = 3'b100;
  localparam logic [2:0] c_mop_divu   = 3'b101;
  localparam logic [2:0] c_mop_rem    = 3'b110;
  localparam logic [2:0] c_mop_remu   = 3'b111;

  // branch funct3
  localparam logic [2:0] c_br_eq  = 3'b000;
  localparam logic [2:0] c_br_ne  = 3'b001;
  localparam logic [2:0] c_br_lt  = 3'b100;
  localparam logic [2:0] c_br_ge  = 3'b101;
  localparam logic [2:0] c_br_ltu = 3'b110;
  localparam logic [2:0] c_br_geu = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_muldiv_iter.sv
`default_nettype none
// ============================================================
// Module   : muldiv_iter
// Purpose  : one-bit-per-cycle shift-add multiply / restoring divide on magnitudes
// Revision : 1.0
// ============================================================
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic             r_div, r_busy;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_hi, w_lo, w_b, w_nhi, w_nlo;
  logic             w_div;
  logic [WIDTH:0]   w_sum, w_trial;

  // The start cycle already performs the first step on the incoming operands,
  // so the last step lands on the edge before the top's fix-up edge.
  always_comb begin
    w_hi    = i_start ? '0 : r_hi;
    w_lo    = i_start ? i_a : r_lo;
    w_b     = i_start ? i_b : r_b;
    w_div   = i_start ? i_is_div : r_div;
    w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
    w_trial = {w_hi, w_lo[WIDTH-1]} - {1'b0, w_b};
    if (w_div) begin
      if (w_trial[WIDTH]) begin
        w_nhi = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
        w_nlo = {w_lo[WIDTH-2:0], 1'b0};
      end else begin
        w_nhi = w_trial[WIDTH-1:0];
        w_nlo = {w_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      w_nhi = w_sum[WIDTH:1];
      w_nlo = {w_sum[0], w_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_div  <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH - 1);
      r_hi   <= w_nhi;
      r_lo   <= w_nlo;
      r_b    <= i_b;
      r_div  <= i_is_div;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_done = r_busy && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================
// Module   : alu_seq
// Purpose  : execute-stage ALU, single-cycle base ops plus iterative RV32M
// Revision : 1.0
// ============================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_sub,
  input  logic             i_arith_shift,
  input  logic             i_muldiv,
  input  logic [2:0]       i_branch_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_will_branch
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic [WIDTH-1:0] r_y;
  logic             r_br, r_neg_q, r_neg_r;
  logic [2:0]       r_mop;

  logic             w_accept, w_branch, w_a_neg, w_b_neg, w_corner, w_start, w_done;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_base, w_a_mag, w_b_mag, w_corner_y, w_fix, w_hi, w_lo;

  assign o_ready       = (r_state == IDLE) || ((r_state == DONE) && i_ready);
  assign o_valid       = (r_state == DONE);
  assign o_y           = r_y;
  assign o_will_branch = r_br;
  assign w_accept      = i_valid && o_ready;
  assign w_shamt       = i_b[SHW-1:0];

  always_comb begin
    w_base = '0;
    case (i_op)
      c_op_add:  w_base = i_sub ? (i_a - i_b) : (i_a + i_b);
      c_op_sll:  w_base = i_a << w_shamt;
      c_op_slt:  w_base = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      c_op_sltu: w_base = {{(WIDTH-1){1'b0}}, i_a < i_b};
      c_op_xor:  w_base = i_a ^ i_b;
      c_op_sr: begin
        // kept out of a ?: so the signed operand is not coerced to unsigned
        if (i_arith_shift) w_base = $signed(i_a) >>> w_shamt;
        else               w_base = i_a >> w_shamt;
      end
      c_op_or:   w_base = i_a | i_b;
      c_op_and:  w_base = i_a & i_b;
      default:   w_base = '0;
    endcase
  end

  always_comb begin
    w_branch = 1'b0;
    case (i_branch_op)
      c_br_eq:  w_branch = (i_a == i_b);
      c_br_ne:  w_branch = (i_a != i_b);
      c_br_lt:  w_branch = ($signed(i_a) <  $signed(i_b));
      c_br_ge:  w_branch = ($signed(i_a) >= $signed(i_b));
      c_br_ltu: w_branch = (i_a <  i_b);
      c_br_geu: w_branch = (i_a >= i_b);
      default:  w_branch = 1'b0;
    endcase
  end

  assign w_a_neg = i_a[WIDTH-1] && ((i_op == c_mop_mulh) || (i_op == c_mop_mulhsu) ||
                                    (i_op == c_mop_div)  || (i_op == c_mop_rem));
  assign w_b_neg = i_b[WIDTH-1] && ((i_op == c_mop_mulh) || (i_op == c_mop_div) ||
                                    (i_op == c_mop_rem));
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  always_comb begin
    w_corner   = 1'b0;
    w_corner_y = '0;
    if (i_op[2]) begin
      if (i_b == '0) begin
        w_corner   = 1'b1;
        w_corner_y = i_op[1] ? i_a : '1;
      end else if (!i_op[0] && (i_a == c_min_neg) && (i_b == '1)) begin
        w_corner   = 1'b1;
        w_corner_y = i_op[1] ? '0 : i_a;
      end
    end
  end

  assign w_start = w_accept && i_muldiv && !w_corner;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_start),
    .i_is_div (i_op[2]),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_hi     (w_hi),
    .o_lo     (w_lo),
    .o_done   (w_done)
  );

  // High half of a negated double-width product: ~hi plus the carry out of ~lo+1.
  always_comb begin
    w_fix = '0;
    case (r_mop)
      c_mop_mul:    w_fix = w_lo;
      c_mop_mulh,
      c_mop_mulhsu,
      c_mop_mulhu:  w_fix = r_neg_q ? (~w_hi + {{(WIDTH-1){1'b0}}, w_lo == '0}) : w_hi;
      c_mop_div,
      c_mop_divu:   w_fix = r_neg_q ? -w_lo : w_lo;
      c_mop_rem,
      c_mop_remu:   w_fix = r_neg_r ? -w_hi : w_hi;
      default:      w_fix = w_lo;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_br    <= 1'b0;
      r_mop   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_mop   <= i_op;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (!i_muldiv) begin
              r_y     <= w_base;
              r_br    <= w_branch;
              r_state <= DONE;
            end else begin
              r_br <= 1'b0;
              if (w_corner) begin
                r_y     <= w_corner_y;
                r_state <= DONE;
              end else begin
                r_state <= i_op[2] ? DIV : MUL;
              end
            end
          end else if ((r_state == DONE) && i_ready) begin
            r_state <= IDLE;
          end
        end
        MUL, DIV: begin
          if (w_done) begin
            r_y     <= w_fix;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================
// Module   : tb_alu_seq
// Purpose  : scoreboard bench for alu_seq (32-bit and 16-bit instances)
// Revision : 1.0
// ============================================================
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic [2:0]  op, bop;
  logic        sub, ars, md, br;

  logic        v16, rdy16, ov16, br16;
  logic [15:0] a16, b16, y16;
  logic [2:0]  op16;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] q_y[$];
  logic        q_br[$];
  string       q_tag[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(in_ready),
    .i_a(a), .i_b(b), .i_op(op), .i_sub(sub), .i_arith_shift(ars),
    .i_muldiv(md), .i_branch_op(bop), .o_valid(out_valid), .i_ready(out_ready),
    .o_y(y), .o_will_branch(br)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v16), .o_ready(rdy16),
    .i_a(a16), .i_b(b16), .i_op(op16), .i_sub(1'b0), .i_arith_shift(1'b0),
    .i_muldiv(1'b1), .i_branch_op(3'b000), .o_valid(ov16), .i_ready(1'b1),
    .o_y(y16), .o_will_branch(br16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pops one expectation for every result handshake seen on the 32-bit DUT.
  task automatic sb_step();
    string t;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_pending", 64'(q_y.size() != 0), 64'd1);
      if (q_y.size() != 0) begin
        t = q_tag.pop_front();
        chk({t, "_y"}, 64'(y), 64'(q_y.pop_front()));
        chk({t, "_br"}, 64'(br), 64'(q_br.pop_front()));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [2:0] iop, input logic isub, input logic iars,
                      input logic imd, input logic [2:0] ibop,
                      input logic [31:0] ey, input logic eb, input logic push);
    int n;
    n = 0;
    a = ia; b = ib; op = iop; sub = isub; ars = iars; md = imd; bop = ibop;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, 64'(n < 200), 64'd1);
    if (push) begin
      q_y.push_back(ey);
      q_br.push_back(eb);
      q_tag.push_back(tag);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after an accept edge; lat=1 means valid in the very next cycle.
  task automatic wait_valid(output int lat, output logic rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic rs;
    logic stable;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; bop = '0; sub = 1'b0; ars = 1'b0; md = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_br", 64'(br), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    send("add_ovf", 32'h7FFFFFFF, 32'd1, c_op_add, 1'b0, 1'b0, 1'b0, 3'b010, 32'h80000000, 1'b0, 1'b1);
    chk("add_lat1", 64'(out_valid), 64'd1);
    send("sub", 32'd5, 32'd7, c_op_add, 1'b1, 1'b0, 1'b0, c_br_eq, 32'hFFFFFFFE, 1'b0, 1'b1);
    chk("sub_b2b", 64'(out_valid), 64'd1);
    send("br_lt", 32'hFFFFFFFF, 32'd1, c_op_and, 1'b0, 1'b0, 1'b0, c_br_lt, 32'd1, 1'b1, 1'b1);
    send("br_ltu", 32'hFFFFFFFF, 32'd1, c_op_xor, 1'b0, 1'b0, 1'b0, c_br_ltu, 32'hFFFFFFFE, 1'b0, 1'b1);
    send("sll", 32'd1, 32'h21, c_op_sll, 1'b0, 1'b0, 1'b0, c_br_ne, 32'd2, 1'b1, 1'b1);
    send("sra", 32'h80000000, 32'd4, c_op_sr, 1'b0, 1'b1, 1'b0, c_br_ge, 32'hF8000000, 1'b0, 1'b1);
    send("srl", 32'h80000000, 32'd4, c_op_sr, 1'b0, 1'b0, 1'b0, c_br_geu, 32'h08000000, 1'b1, 1'b1);
    send("slt", 32'hFFFFFFFF, 32'd1, c_op_slt, 1'b0, 1'b0, 1'b0, 3'b011, 32'd1, 1'b0, 1'b1);
    send("sltu", 32'hFFFFFFFF, 32'd1, c_op_sltu, 1'b0, 1'b0, 1'b0, c_br_eq, 32'd0, 1'b0, 1'b1);
    send("or", 32'hF0F00000, 32'h00000F0F, c_op_or, 1'b0, 1'b0, 1'b0, c_br_geu, 32'hF0F00F0F, 1'b1, 1'b1);
    tick();

    send("mulh", 32'h80000000, 32'h80000000, c_mop_mulh, 1'b0, 1'b0, 1'b1, c_br_eq, 32'h40000000, 1'b0, 1'b1);
    wait_valid(lat, rs);
    chk("mulh_lat", 64'(lat), 64'd33);
    chk("mulh_busy_ready", 64'(rs), 64'd0);

    send("div", 32'hFFFFFFF9, 32'd2, c_mop_div, 1'b0, 1'b0, 1'b1, c_br_eq, 32'hFFFFFFFD, 1'b0, 1'b1);
    send("rem", 32'hFFFFFFF9, 32'd2, c_mop_rem, 1'b0, 1'b0, 1'b1, c_br_eq, 32'hFFFFFFFF, 1'b0, 1'b1);
    send("rem_negb", 32'd7, 32'hFFFFFFFE, c_mop_rem, 1'b0, 1'b0, 1'b1, c_br_eq, 32'd1, 1'b0, 1'b1);
    send("divu", 32'd100, 32'd7, c_mop_divu, 1'b0, 1'b0, 1'b1, c_br_eq, 32'd14, 1'b0, 1'b1);
    send("remu", 32'd100, 32'd7, c_mop_remu, 1'b0, 1'b0, 1'b1, c_br_eq, 32'd2, 1'b0, 1'b1);
    send("mulhsu", 32'hFFFFFFFF, 32'd2, c_mop_mulhsu, 1'b0, 1'b0, 1'b1, c_br_eq, 32'hFFFFFFFF, 1'b0, 1'b1);
    send("mulhu", 32'hFFFFFFFF, 32'hFFFFFFFF, c_mop_mulhu, 1'b0, 1'b0, 1'b1, c_br_eq, 32'hFFFFFFFE, 1'b0, 1'b1);
    send("mul", 32'h12345678, 32'h10, c_mop_mul, 1'b0, 1'b0, 1'b1, c_br_eq, 32'h23456780, 1'b0, 1'b1);
    send("divu0", 32'h1234, 32'd0, c_mop_divu, 1'b0, 1'b0, 1'b1, c_br_eq, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_valid(lat, rs);
    chk("divu0_lat", 64'(lat), 64'd1);
    send("remu0", 32'h1234, 32'd0, c_mop_remu, 1'b0, 1'b0, 1'b1, c_br_eq, 32'h1234, 1'b0, 1'b1);
    send("div_ovf", 32'h80000000, 32'hFFFFFFFF, c_mop_div, 1'b0, 1'b0, 1'b1, c_br_eq, 32'h80000000, 1'b0, 1'b1);
    wait_valid(lat, rs);
    chk("div_ovf_lat", 64'(lat), 64'd1);
    send("rem_ovf", 32'h80000000, 32'hFFFFFFFF, c_mop_rem, 1'b0, 1'b0, 1'b1, c_br_eq, 32'd0, 1'b0, 1'b1);
    tick();
    tick();

    out_ready = 1'b0;
    send("bp_mul", 32'd6, 32'd7, c_mop_mul, 1'b0, 1'b0, 1'b1, c_br_eq, 32'd42, 1'b0, 1'b1);
    wait_valid(lat, rs);
    chk("bp_lat", 64'(lat), 64'd33);
    chk("bp_busy_ready", 64'(rs), 64'd0);
    stable = 1'b1;
    repeat (5) begin
      if (!(out_valid === 1'b1 && y === 32'd42 && in_ready === 1'b0)) stable = 1'b0;
      tick();
    end
    chk("bp_hold", 64'(stable), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_release", 64'(out_valid), 64'd0);

    send("rst_divu", 32'd1000, 32'd3, c_mop_divu, 1'b0, 1'b0, 1'b1, c_br_eq, 32'd0, 1'b0, 1'b0);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_y", 64'(y), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    send("post_rst_mul", 32'd3, 32'd5, c_mop_mul, 1'b0, 1'b0, 1'b1, c_br_eq, 32'd15, 1'b0, 1'b1);
    wait_valid(lat, rs);
    chk("post_rst_lat", 64'(lat), 64'd33);
    tick();

    a16 = 16'hFFFF; b16 = 16'hFFFF; op16 = c_mop_mulhu; v16 = 1'b1;
    chk("w16_ready", 64'(rdy16), 64'd1);
    tick();
    v16 = 1'b0;
    lat = 1;
    while (ov16 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk("w16_lat", 64'(lat), 64'd17);
    chk("w16_y", 64'(y16), 64'hFFFE);
    tick();

    chk("sb_drained", 64'(q_y.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the single-cycle integer ALU, adding the RV32M multiply/divide ops.
- Sits in the execute stage.
- Base ops and branch compare complete in 1 cycle.
- M ops run on an iterative one-bit-per-cycle datapath.
- Valid/ready handshakes on both sides let the pipeline stall on long ops.

Parameters:
- WIDTH, 32, operand/result width (power of two, >= 8).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_op  in  3  funct3: base op, or M op when i_muldiv=1.
- i_sub  in  1  subtract select for op 000 (base only).
- i_arith_shift  in  1  arithmetic right shift for op 101 (base only).
- i_muldiv  in  1  selects M-extension decode of i_op.
- i_branch_op  in  3  branch funct3.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_y  out  WIDTH  result.
- o_will_branch  out  1  branch decision, registered with o_y.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - state=IDLE, o_valid=0, o_y=0, o_will_branch=0, o_ready=1 from the following cycle.
  - Reset mid-operation abandons the operation with no result.
- Accept: i_valid && o_ready on a clock edge. Operands and controls are captured; inputs are don't-care afterwards.
- o_ready=1 only in IDLE, or in DONE when i_ready=1 (back-to-back issue).
- States:
  - IDLE.
  - BASE: not a distinct state; goes directly to DONE.
  - MUL, DIV: counter cnt runs from WIDTH-1 down to 0.
  - DONE.
- Base op (i_muldiv=0): the result and o_will_branch are registered on the accept edge; o_valid=1 in the next cycle (latency 1). Encoding:
  - 000 add/sub (wraps mod 2^WIDTH)
  - 001 sll by b[SHW-1:0]
  - 010 slt signed
  - 011 sltu
  - 100 xor
  - 101 srl/sra by b[SHW-1:0]
  - 110 or
  - 111 and
- Branch encoding:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - 010 and 011 give 0.
  - o_will_branch is computed on base requests only; M requests return 0.
- M op (i_muldiv=1):
  - 000 MUL returns the low WIDTH bits of the product.
  - 001 MULH: signed x signed, high WIDTH bits.
  - 010 MULHSU: signed a x unsigned b, high bits.
  - 011 MULHU: unsigned high bits.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU. Quotients truncate toward zero; the remainder takes the sign of the dividend.
  - Iterative datapath works on magnitudes, one bit per cycle for WIDTH cycles, then a sign fix-up in the transition to DONE.
  - o_valid rises exactly WIDTH+1 cycles after the accept edge.
- Division boundaries (detected at accept, go straight to DONE with latency 1):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = most negative, b = -1): DIV gives a; REM gives 0.
- DONE:
  - o_y, o_will_branch and o_valid hold until i_ready=1.
  - On o_valid && i_ready with no new accept: go to IDLE, o_valid=0 next cycle.
  - Simultaneous completion-handshake and new accept is legal; the new request proceeds as from IDLE.
- While in MUL or DIV: o_ready=0; i_valid is ignored; i_ready has no effect.

Decomposition:
- Package alu_pkg holds:
  - localparams for base op, M op and branch funct3 encodings;
  - the state enum (IDLE, MUL, DIV, DONE);
  - the WIDTH default.
- One sub-module, muldiv_iter, is natural. It contains the shift-add multiplier and restoring divider on unsigned magnitudes:
  - inputs: start, is_div, magnitude a/b;
  - outputs: hi/lo (product), or quotient/remainder;
  - done after WIDTH cycles.
- The top handles sign decode, corner cases, the FSM and the output handshake.

Test Plan:
- Base add, back-to-back: a=0x7FFFFFFF, b=1, op 000, i_sub=0; then a=5, b=7, i_sub=1, both with i_ready held 1.
  - First result: o_y=0x80000000, o_valid 1 cycle after accept.
  - Second result: o_y=0xFFFFFFFE on the following cycle, with no bubble.
- Branch: a=0xFFFFFFFF, b=1, branch_op 100 -> o_will_branch=1. Same operands with branch_op 110 -> 0.
- MULH: a=0x80000000, b=0x80000000, op 001, muldiv=1.
  - o_y=0x40000000.
  - o_valid exactly 33 cycles after accept.
  - o_ready=0 throughout.
- Divide corners:
  - DIV a=-7, b=2 -> 0xFFFFFFFD.
  - REM -7,2 -> 0xFFFFFFFF.
  - DIVU x/0 -> 0xFFFFFFFF, latency 1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Backpressure: i_ready=0 for 5 cycles after a MUL completes.
  - o_y and o_valid stay stable; o_ready=0 throughout.
  - i_ready=1 -> o_valid drops next cycle.
- Reset mid-DIV: assert i_rst_n=0 at cycle 10 of a DIVU.
  - Next cycle: o_valid=0, o_y=0, o_ready=1.
  - A fresh MUL 3*5 then returns 15.
- WIDTH=16 instance: MULHU 0xFFFF*0xFFFF -> 0xFFFE with latency 17.
